// File: rtl/msi_bus_arbiter.sv
// rtl/msi_bus_arbiter.sv - snooping-bus sequencer for two MSI cache controllers
// Sticky per-CPU request capture, round-robin pick, snoop, then C2C/MEM/INVAL grant.
module msi_bus_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        read_miss,
  input  logic [1:0]        write_miss,
  input  logic [1:0]        invalidate,
  input  logic [ADDR_W-1:0] BICO0,
  input  logic [ADDR_W-1:0] BICO1,
  input  logic [1:0]        cpu_search_found,
  input  logic [DATA_W-1:0] send_other_proc_data0,
  input  logic [DATA_W-1:0] send_other_proc_data1,
  input  logic              u_rdy,
  output logic [1:0]        grant,
  output logic [1:0]        cpu_search,
  output logic [ADDR_W-1:0] BOCI0,
  output logic [ADDR_W-1:0] BOCI1,
  output logic [1:0]        invalidate_from_other_cpu,
  output logic [1:0]        cpu_datasel0,
  output logic [1:0]        cpu_datasel1,
  output logic [DATA_W-1:0] other_proc_data0,
  output logic [DATA_W-1:0] other_proc_data1,
  output logic              bus_busy,
  output logic              bus_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SNOOP, S_C2C, S_MEM, S_INVAL, S_REL
  } state_t;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INVAL = 2'd2;
  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_t              state_q;
  logic [1:0]          pend_q;
  logic [1:0]          op_q   [2];
  logic [ADDR_W-1:0]   addr_q [2];
  logic                last_q;
  logic                win_q;
  logic [1:0]          cur_op_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [1:0]          req_any;
  logic [1:0]          new_op   [2];
  logic [ADDR_W-1:0]   bico     [2];
  logic [1:0]          eff_pend;
  logic [1:0]          eff_op   [2];
  logic [ADDR_W-1:0]   eff_addr [2];
  logic                pick;
  logic                peer;
  logic                timeout;

  logic [ADDR_W-1:0]   boci [2];
  logic [1:0]          dsel [2];
  logic [DATA_W-1:0]   opd  [2];
  logic [DATA_W-1:0]   send [2];

  assign bico[0] = BICO0;
  assign bico[1] = BICO1;
  assign send[0] = send_other_proc_data0;
  assign send[1] = send_other_proc_data1;
  assign req_any = read_miss | write_miss | invalidate;
  assign peer    = ~win_q;

  // A request seen this cycle counts as pending so IDLE can win it immediately.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      new_op[i]   = write_miss[i] ? OP_WRITE : (invalidate[i] ? OP_INVAL : OP_READ);
      eff_op[i]   = pend_q[i] ? op_q[i]   : new_op[i];
      eff_addr[i] = pend_q[i] ? addr_q[i] : bico[i];
    end
    eff_pend = pend_q | req_any;
    pick     = (eff_pend == 2'b11) ? ~last_q : eff_pend[1];
  end

  assign timeout = (MEM_TIMEOUT != 0) && (state_q == S_MEM) && !u_rdy &&
                   (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= 2'b00;
      op_q[0]    <= OP_READ;
      op_q[1]    <= OP_READ;
      addr_q[0]  <= '0;
      addr_q[1]  <= '0;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      cur_op_q   <= OP_READ;
      cur_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!pend_q[i] && req_any[i]) begin
          pend_q[i] <= 1'b1;
          op_q[i]   <= new_op[i];
          addr_q[i] <= bico[i];
        end
      end
      case (state_q)
        S_IDLE: begin
          if (|eff_pend) begin
            win_q      <= pick;
            cur_op_q   <= eff_op[pick];
            cur_addr_q <= eff_addr[pick];
            state_q    <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          cnt_q <= '0;
          if (cur_op_q != OP_READ)         state_q <= S_INVAL;
          else if (cpu_search_found[peer]) state_q <= S_C2C;
          else                             state_q <= S_MEM;
        end
        S_C2C: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= S_REL;
        end
        S_MEM: begin
          cnt_q <= cnt_q + 1'b1;
          if (u_rdy || timeout) state_q <= S_REL;
        end
        S_INVAL: state_q <= S_REL;
        S_REL: begin
          pend_q[win_q] <= 1'b0;
          last_q        <= win_q;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bus outputs decode from registered state; only the peer data path is a live mux.
  always_comb begin
    grant                     = 2'b00;
    cpu_search                = 2'b00;
    invalidate_from_other_cpu = 2'b00;
    boci[0] = '0;
    boci[1] = '0;
    dsel[0] = 2'b00;
    dsel[1] = 2'b00;
    opd[0]  = '0;
    opd[1]  = '0;
    case (state_q)
      S_SNOOP: begin
        cpu_search[peer] = 1'b1;
        boci[peer]       = cur_addr_q;
      end
      S_C2C: begin
        grant[win_q]     = 1'b1;
        cpu_search[peer] = 1'b1;
        boci[peer]       = cur_addr_q;
        dsel[win_q]      = 2'b01;
        opd[win_q]       = send[peer];
      end
      S_MEM:   grant[win_q] = 1'b1;
      S_INVAL: begin
        grant[win_q]                    = 1'b1;
        invalidate_from_other_cpu[peer] = 1'b1;
        boci[peer]                      = cur_addr_q;
      end
      default: ;
    endcase
  end

  assign BOCI0            = boci[0];
  assign BOCI1            = boci[1];
  assign cpu_datasel0     = dsel[0];
  assign cpu_datasel1     = dsel[1];
  assign other_proc_data0 = opd[0];
  assign other_proc_data1 = opd[1];
  assign bus_busy         = (state_q != S_IDLE);
  assign bus_error        = timeout;

endmodule
